// File: rtl/rx_stats_counter.sv
// rx_stats_counter
//   Per-frame receive statistics on the MAC receive clock. Frame length is
//   accumulated over the 64-bit beats of each frame. At the last beat the frame
//   is classified as good or bad, and three free-running totals are updated.
//   The outputs come straight from flops. Each one changes at most once per
//   frame completion or clear, so it can feed a slow-domain crossing stage.
//
// Ports
//   clk          receive clock, rising edge
//   rst          synchronous active-high reset
//   rx_valid     beat present (always consumed)
//   rx_last      final beat of frame, qualified by rx_valid
//   rx_keep[7:0] byte enables; beat length = popcount
//   rx_good      MAC status, sampled on the last beat only
//   clear        one-cycle pulse that zeroes all counters
//   good_frames  accepted frame count   (W bits, wraps)
//   bad_frames   rejected frame count   (W bits, wraps)
//   good_bytes   accepted byte total    (W bits, wraps)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | between frames, acc is 0; next valid beat starts a frame
// FRAME | inside a multi-beat frame, acc holds the bytes seen so far

module rx_stats_counter #(
  parameter int W       = 32,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_valid,
  input  logic         rx_last,
  input  logic [7:0]   rx_keep,
  input  logic         rx_good,
  input  logic         clear,
  output logic [W-1:0] good_frames,
  output logic [W-1:0] bad_frames,
  output logic [W-1:0] good_bytes
);

  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);

  typedef enum logic {IDLE, FRAME} state_t;

  state_t       state_q, state_d;
  logic [15:0]  acc_q, acc_d;
  logic [W-1:0] good_frames_q, good_frames_d;
  logic [W-1:0] bad_frames_q, bad_frames_d;
  logic [W-1:0] good_bytes_q, good_bytes_d;

  logic [3:0]   beat_bytes;
  logic [15:0]  base;
  logic [16:0]  sum;
  logic [15:0]  len;
  logic [W-1:0] len_w;
  logic         done;
  logic         frame_ok;

  always_comb begin
    beat_bytes = 4'd0;
    for (int i = 0; i < 8; i++) begin
      beat_bytes = beat_bytes + {3'b000, rx_keep[i]};
    end
  end

  always_comb begin
    // A beat taken in IDLE starts from zero, whatever acc holds.
    base     = (state_q == FRAME) ? acc_q : 16'h0000;
    sum      = {1'b0, base} + {13'b0, beat_bytes};
    // Saturating: a pinned 0xFFFF is always larger than any legal frame.
    len      = sum[16] ? 16'hFFFF : sum[15:0];
    len_w    = W'(len);
    done     = rx_valid & rx_last;
    frame_ok = rx_good && (len >= MIN_L) && (len <= MAX_L);

    state_d       = state_q;
    acc_d         = acc_q;
    good_frames_d = good_frames_q;
    bad_frames_d  = bad_frames_q;
    good_bytes_d  = good_bytes_q;

    if (rx_valid) begin
      if (rx_last) begin
        state_d = IDLE;
        acc_d   = 16'h0000;
      end else begin
        state_d = FRAME;
        acc_d   = len;
      end
    end

    // Clear wins over a coinciding completion. It leaves the frame tracking alone.
    if (clear) begin
      good_frames_d = '0;
      bad_frames_d  = '0;
      good_bytes_d  = '0;
    end else if (done) begin
      if (frame_ok) begin
        good_frames_d = good_frames_q + 1'b1;
        good_bytes_d  = good_bytes_q + len_w;
      end else begin
        bad_frames_d  = bad_frames_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      acc_q         <= 16'h0000;
      good_frames_q <= '0;
      bad_frames_q  <= '0;
      good_bytes_q  <= '0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      good_frames_q <= good_frames_d;
      bad_frames_q  <= bad_frames_d;
      good_bytes_q  <= good_bytes_d;
    end
  end

  assign good_frames = good_frames_q;
  assign bad_frames  = bad_frames_q;
  assign good_bytes  = good_bytes_q;

endmodule
